ans_session_ctrl: RTL
=====================

Name: ans_session_ctrl

Overview:
Session sequencer in front of the ANS core (loader/encoder/decoder behind a 2-bit cmd).
- Takes one host "start" request and drives the core's cmd through a full session: optional frequency-table load, one settle cycle, then an encode or decode run of a programmed symbol count, then drain.
- Gates and counts the 4-bit valid/ready streams between host pins and core, so the core never sees a mode change mid-transfer.

Parameters:
SYM_W, 4, symbol/nibble width (matches core).
TBL_LEN, 16, count nibbles per table load (2**SYM_W).
LEN_W, 8, width of the session symbol-count field.
DRAIN_CYC, 4, consecutive cycles of core_out_vld low that end a session (min 1).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  session request, sampled in IDLE only
op  in  2  01 = encode, 10 = decode; other values illegal
load_tbl  in  1  1 = run LOAD phase first
len  in  LEN_W  symbols to feed in RUN, latched at start
host_in  in  SYM_W  host input nibble
host_in_vld  in  1  host input valid
host_in_rdy  out  1  host input ready
host_out  out  SYM_W  output nibble to host
host_out_vld  out  1  output valid to host
host_out_rdy  in  1  host output ready
core_cmd  out  2  core mode: 00 idle, 01 enc, 10 dec, 11 load
core_in  out  SYM_W  nibble to core
core_in_vld  out  1  valid to core
core_in_rdy  in  1  core ready
core_out  in  SYM_W  core output nibble
core_out_vld  in  1  core output valid
core_out_rdy  out  1  ready to core
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at session end
err  out  1  sticky illegal-op flag, cleared by next accepted start

Behaviour:
- Reset (async, rst_n low): state IDLE; core_cmd=00, busy=0, done=0, err=0, host_in_rdy=0, core_in_vld=0, host_out_vld=0, core_out_rdy=0; counters 0.
- States: IDLE, LOAD, SETTLE, RUN, DRAIN, DONE. core_cmd is registered and changes only on state transitions.
- IDLE:
  - start=1 with op in {01,10}: latch op/len, clear err, go to LOAD if load_tbl else SETTLE.
  - start=1 with illegal op: set err, stay IDLE.
- LOAD: core_cmd=11; pass input stream through. Count beats (host_in_vld & core_in_rdy). After beat TBL_LEN, go to SETTLE.
- SETTLE: exactly one cycle with core_cmd=00, so core engines see a mode edge. Then go to RUN with core_cmd=op.
- RUN: pass input stream while in_cnt < len; count accepted beats. When in_cnt == len (immediately if len=0), go to DRAIN.
- DRAIN: input gated. Output passthrough stays active in RUN and DRAIN. An idle counter increments each cycle core_out_vld=0 and resets to 0 on core_out_vld=1. At DRAIN_CYC, go to DONE.
- DONE: done=1 for one cycle, core_cmd=00, then IDLE.
- Input passthrough (combinational, no buffering):
  - core_in = host_in.
  - core_in_vld = host_in_vld & gate; host_in_rdy = core_in_rdy & gate.
  - gate = 1 only in LOAD and in RUN with in_cnt < len.
- Output passthrough: host_out = core_out; host_out_vld = core_out_vld & ogate; core_out_rdy = host_out_rdy & ogate; ogate = RUN or DRAIN.
- A stalled output (core_out_vld=1, host_out_rdy=0) holds DRAIN indefinitely; no timeout.
- start while busy is ignored. Reset mid-session returns to IDLE immediately; a partial table load is not recovered.
- Counters: in_cnt is LEN_W bits and never wraps (len ≤ 2**LEN_W-1); table counter is clog2(TBL_LEN)+1 bits.

Optional Feature:
ANS_SESSION_ABORT_EN
- Defined: adds input port abort (1 bit). abort=1 in any non-IDLE state forces core_cmd=00 and the input/output gates to 0 that cycle, sets err, and returns to IDLE next cycle with no done pulse. abort has priority over every other transition; abort in IDLE is ignored.
- Undefined: no abort port; sessions end only through DONE or reset.

Decomposition:
- Shared package ans_pkg holds:
  - SYM_W
  - CMD_IDLE/CMD_ENC/CMD_DEC/CMD_LOAD encodings (00/01/10/11)
  - the session state enum
  - TBL_LEN
- The core top also imports ans_pkg.
- One sub-module, ans_stream_gate: valid/ready gate with a beat-count output, instantiated for the input and output paths.

Test Plan:
1. start, op=01, load_tbl=1, len=3, host streams 16 nibbles then 3, core always ready.
   - core_cmd sequence 11 (16 beats), 00 (1 cycle), 01; exactly 3 RUN beats pass; done pulses DRAIN_CYC+1 cycles after the last core_out_vld.
2. load_tbl=0, op=10, len=0.
   - IDLE→SETTLE→RUN→DRAIN; host_in_rdy never high; done after DRAIN_CYC idle cycles.
3. start with op=00, then start with op=01.
   - err=1 and busy=0 after the first; err cleared on the second accept.
4. Core drops core_in_rdy for 5 cycles mid-LOAD.
   - host_in_rdy low for those cycles; beat count unaffected; still exactly 16 beats in LOAD.
5. In DRAIN, host_out_rdy held low with core_out_vld=1 for 20 cycles.
   - No done pulse; done follows DRAIN_CYC cycles after the output clears.
6. rst_n pulsed low mid-RUN (and abort=1 mid-LOAD when ANS_SESSION_ABORT_EN is defined).
   - Asynchronous return to all reset values; for abort, err=1 with no done pulse.

Source files
------------

// File: rtl/ans_pkg.sv
// Shared definitions for the ANS session sequencer and the ANS core:
// symbol width, table length, core command encodings and session states.
package ans_pkg;

    localparam int SYM_W   = 4;
    localparam int TBL_LEN = 1 << SYM_W;

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_ENC  = 2'b01;
    localparam logic [1:0] CMD_DEC  = 2'b10;
    localparam logic [1:0] CMD_LOAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Only encode and decode may be requested by the host.
    function automatic logic op_legal(input logic [1:0] op);
        return (op == CMD_ENC) || (op == CMD_DEC);
    endfunction

endpackage

// File: rtl/ans_stream_gate.sv
// Combinational valid/ready gate with a small event counter alongside.
// The counter increments on i_cnt_inc and clears on i_cnt_clr (clear wins),
// so the parent decides what an "event" is for each path.
module ans_stream_gate
    import ans_pkg::*;
#(
    parameter int W     = SYM_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_gate,
    input  logic [W-1:0]     i_s_data,
    input  logic             i_s_vld,
    output logic             o_s_rdy,
    output logic [W-1:0]     o_m_data,
    output logic             o_m_vld,
    input  logic             i_m_rdy,
    input  logic             i_cnt_inc,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    assign o_m_data = i_s_data;
    assign o_m_vld  = i_s_vld & i_gate;
    assign o_s_rdy  = i_m_rdy & i_gate;
    assign o_cnt    = r_cnt;

    // Event counter: clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_cnt <= '0;
        end else if (i_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ans_session_ctrl.sv
// Session sequencer in front of the ANS core: optional table load, one
// settle cycle, an encode/decode run of len symbols, then drain and done.
// Optional macro ANS_SESSION_ABORT_EN adds an abort input that cancels a
// session in any busy state.
module ans_session_ctrl
    import ans_pkg::*;
#(
    parameter int LEN_W     = 8,
    parameter int DRAIN_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ANS_SESSION_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             load_tbl,
    input  logic [LEN_W-1:0] len,
    input  logic [SYM_W-1:0] host_in,
    input  logic             host_in_vld,
    output logic             host_in_rdy,
    output logic [SYM_W-1:0] host_out,
    output logic             host_out_vld,
    input  logic             host_out_rdy,
    output logic [1:0]       core_cmd,
    output logic [SYM_W-1:0] core_in,
    output logic             core_in_vld,
    input  logic             core_in_rdy,
    input  logic [SYM_W-1:0] core_out,
    input  logic             core_out_vld,
    output logic             core_out_rdy,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int               IDLE_W    = $clog2(DRAIN_CYC) + 1;
    localparam logic [LEN_W-1:0] TBL_LAST  = LEN_W'(TBL_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_CYC - 1);

    state_t             r_state, w_state_next;
    logic [1:0]         r_core_cmd, w_core_cmd_next;
    logic [1:0]         r_op, w_op_next;
    logic [LEN_W-1:0]   r_len, w_len_next;
    logic               r_err, w_err_next;

    logic               w_abort;
    logic               w_in_gate, w_out_gate, w_in_fire;
    logic               w_in_cnt_clr, w_idle_inc, w_idle_clr;
    logic [LEN_W-1:0]   w_in_cnt;
    logic [IDLE_W-1:0]  w_idle_cnt;

`ifdef ANS_SESSION_ABORT_EN
    assign w_abort = abort & (r_state != ST_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // The input counter serves as table-beat counter in LOAD and symbol
    // counter in RUN; it is cleared in IDLE and in the SETTLE gap between.
    assign w_in_gate    = ((r_state == ST_LOAD) ||
                           ((r_state == ST_RUN) && (w_in_cnt < r_len))) && !w_abort;
    assign w_out_gate   = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !w_abort;
    assign w_in_fire    = host_in_vld & core_in_rdy & w_in_gate;
    assign w_in_cnt_clr = (r_state == ST_IDLE) || (r_state == ST_SETTLE);

    // The output-side counter measures consecutive quiet cycles in DRAIN.
    assign w_idle_inc = (r_state == ST_DRAIN) && !core_out_vld;
    assign w_idle_clr = (r_state != ST_DRAIN) || core_out_vld;

    ans_stream_gate #(.W(SYM_W), .CNT_W(LEN_W)) u_in_gate (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_gate    (w_in_gate),
        .i_s_data  (host_in),
        .i_s_vld   (host_in_vld),
        .o_s_rdy   (host_in_rdy),
        .o_m_data  (core_in),
        .o_m_vld   (core_in_vld),
        .i_m_rdy   (core_in_rdy),
        .i_cnt_inc (w_in_fire),
        .i_cnt_clr (w_in_cnt_clr),
        .o_cnt     (w_in_cnt)
    );

    ans_stream_gate #(.W(SYM_W), .CNT_W(IDLE_W)) u_out_gate (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_gate    (w_out_gate),
        .i_s_data  (core_out),
        .i_s_vld   (core_out_vld),
        .o_s_rdy   (core_out_rdy),
        .o_m_data  (host_out),
        .o_m_vld   (host_out_vld),
        .i_m_rdy   (host_out_rdy),
        .i_cnt_inc (w_idle_inc),
        .i_cnt_clr (w_idle_clr),
        .o_cnt     (w_idle_cnt)
    );

    assign core_cmd = w_abort ? CMD_IDLE : r_core_cmd;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign err      = r_err;

    // Session state, registered core command and latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_core_cmd <= CMD_IDLE;
            r_op       <= CMD_IDLE;
            r_len      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_core_cmd <= w_core_cmd_next;
            r_op       <= w_op_next;
            r_len      <= w_len_next;
            r_err      <= w_err_next;
        end
    end

    // Next-state logic; core_cmd is only updated on state transitions.
    always_comb begin
        w_state_next    = r_state;
        w_core_cmd_next = r_core_cmd;
        w_op_next       = r_op;
        w_len_next      = r_len;
        w_err_next      = r_err;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (op_legal(op)) begin
                        w_op_next  = op;
                        w_len_next = len;
                        w_err_next = 1'b0;
                        if (load_tbl) begin
                            w_state_next    = ST_LOAD;
                            w_core_cmd_next = CMD_LOAD;
                        end else begin
                            w_state_next    = ST_SETTLE;
                            w_core_cmd_next = CMD_IDLE;
                        end
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (w_in_fire && (w_in_cnt == TBL_LAST)) begin
                    w_state_next    = ST_SETTLE;
                    w_core_cmd_next = CMD_IDLE;
                end
            end
            ST_SETTLE: begin
                w_state_next    = ST_RUN;
                w_core_cmd_next = r_op;
            end
            ST_RUN: begin
                if (w_in_cnt == r_len) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_idle_inc && (w_idle_cnt == IDLE_LAST)) begin
                    w_state_next    = ST_DONE;
                    w_core_cmd_next = CMD_IDLE;
                end
            end
            ST_DONE: begin
                w_state_next    = ST_IDLE;
                w_core_cmd_next = CMD_IDLE;
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_core_cmd_next = CMD_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_next    = ST_IDLE;
            w_core_cmd_next = CMD_IDLE;
            w_err_next      = 1'b1;
        end
    end

endmodule
